// File: rtl/gif_frame_fetch_if.sv
// Frame memory read port used by gif_frame_fetch: registered address and read
// enable towards the memory, RGB565 read data back one cycle after sampling.
interface gif_frame_fetch_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/gif_frame_fetch.sv
// Animated GIF pixel fetcher: follows the TFT scan, reads the current animation
// frame from external memory and only switches frames on whole-screen boundaries.
module gif_frame_fetch #(
  parameter int LCD_W       = 320,
  parameter int LCD_H       = 240,
  parameter int IMG_X0      = 80,
  parameter int IMG_Y0      = 80,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int NUM_FRAMES  = 8,
  parameter int FRAME_DELAY = 6,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              framebufferClk,
  input  logic              play,
  input  logic              restart,
  gif_frame_fetch_if.master mem,
  output logic [15:0]       gif_pixel,
  output logic              gif_valid,
  output logic [7:0]        frame_idx,
  output logic              frame_start
);

  localparam int XW = (LCD_W > 1) ? $clog2(LCD_W) : 1;
  localparam int YW = (LCD_H > 1) ? $clog2(LCD_H) : 1;
  localparam int RW = $clog2(FRAME_DELAY + 1);
  localparam logic [XW-1:0]     X_LAST   = XW'(LCD_W - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(LCD_H - 1);
  localparam logic [RW-1:0]     R_LAST   = RW'(FRAME_DELAY - 1);
  localparam logic [7:0]        F_LAST   = 8'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(IMG_W * IMG_H);

  logic              fbclk_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] pix_off_q, pix_off_d;
  logic [ADDR_W-1:0] frame_base_q, frame_base_d;
  logic [7:0]        frame_idx_q, frame_idx_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic              pending_q, pending_d;
  logic              frame_start_q, frame_start_d;
  logic              adv1_q, adv2_q, adv3_q, win3_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic [15:0]       gif_pixel_q;
  logic              gif_valid_q;

  logic advance, x_last, y_last, wrap, in_win;

  assign advance = framebufferClk & ~fbclk_q;
  assign x_last  = (x_q == X_LAST);
  assign y_last  = (y_q == Y_LAST);
  assign wrap    = advance & x_last & y_last;
  assign in_win  = (int'(x_q) >= IMG_X0) && (int'(x_q) < IMG_X0 + IMG_W) &&
                   (int'(y_q) >= IMG_Y0) && (int'(y_q) < IMG_Y0 + IMG_H);

  // Frame state only moves on a screen wrap so a displayed frame never tears.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    pix_off_d     = pix_off_q;
    frame_base_d  = frame_base_q;
    frame_idx_d   = frame_idx_q;
    rcnt_d        = rcnt_q;
    pending_d     = pending_q | restart;
    frame_start_d = 1'b0;

    if (advance) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (wrap) begin
        pix_off_d = '0;
      end else if (in_win) begin
        pix_off_d = pix_off_q + 1'b1;
      end
    end

    if (wrap) begin
      pending_d = 1'b0;
      if (pending_q || restart) begin
        frame_idx_d   = '0;
        frame_base_d  = '0;
        rcnt_d        = '0;
        frame_start_d = 1'b1;
      end else if (play) begin
        if (rcnt_q == R_LAST) begin
          rcnt_d        = '0;
          frame_start_d = 1'b1;
          if (frame_idx_q == F_LAST) begin
            frame_idx_d  = '0;
            frame_base_d = '0;
          end else begin
            frame_idx_d  = frame_idx_q + 8'd1;
            frame_base_d = frame_base_q + FRAME_SZ;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fbclk_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_off_q     <= '0;
      frame_base_q  <= '0;
      frame_idx_q   <= '0;
      rcnt_q        <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      fbclk_q       <= framebufferClk;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_off_q     <= pix_off_d;
      frame_base_q  <= frame_base_d;
      frame_idx_q   <= frame_idx_d;
      rcnt_q        <= rcnt_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Fetch uses the post-advance position; window flag rides along with the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adv1_q      <= 1'b0;
      adv2_q      <= 1'b0;
      adv3_q      <= 1'b0;
      win3_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      gif_pixel_q <= 16'h0000;
      gif_valid_q <= 1'b0;
    end else begin
      adv1_q   <= advance;
      adv2_q   <= adv1_q;
      adv3_q   <= adv2_q;
      mem_rd_q <= 1'b0;
      if (adv1_q) begin
        mem_addr_q <= frame_base_q + pix_off_q;
        mem_rd_q   <= in_win;
      end
      if (adv2_q) begin
        win3_q <= mem_rd_q;
      end
      if (adv3_q) begin
        gif_valid_q <= win3_q;
        gif_pixel_q <= win3_q ? mem.mem_data : 16'h0000;
      end
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign gif_pixel    = gif_pixel_q;
  assign gif_valid    = gif_valid_q;
  assign frame_idx    = frame_idx_q;
  assign frame_start  = frame_start_q;

endmodule

// File: doc/gif_frame_fetch.md
# gif_frame_fetch

Frame-sequencing pixel fetcher for the GIF viewer screen. Tracks the same 320x240 landscape scan as the screen renderer, using `framebufferClk` edges from the TFT driver. Reads RGB565 frame pixels from an external synchronous frame memory for a fixed image window inside the GIF box. Advances through animation frames on whole-screen boundaries, so a frame never tears, and presents `gif_pixel`/`gif_valid` for the renderer to overlay on the box interior.

## Interface
Parameters:
- `LCD_W`, 320, scan width; must match the TFT driver window.
- `LCD_H`, 240, scan height.
- `IMG_X0`, 80, image window left column.
- `IMG_Y0`, 80, image window top row. The window lies inside the box interior, rows 51..228.
- `IMG_W`, 160, image width in pixels.
- `IMG_H`, 120, image height in pixels.
- `NUM_FRAMES`, 8, number of animation frames, 1..255.
- `FRAME_DELAY`, 6, full screen refreshes per animation frame, ≥1.
- `ADDR_W`, 18, memory address width. Must satisfy NUM_FRAMES·IMG_W·IMG_H ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `framebufferClk`  in  1  pixel-advance strobe from the TFT driver, synchronous to `clk`.
- `play`  in  1  1 = animate, 0 = hold the current frame.
- `restart`  in  1  single-cycle pulse; request a return to frame 0.
- `mem_addr`  out  ADDR_W  frame memory read address (registered).
- `mem_rd`  out  1  read enable (registered).
- `mem_data`  in  16  RGB565 read data; valid one cycle after the memory samples `mem_addr`.
- `gif_pixel`  out  16  RGB565 pixel for the current scan position; 0 outside the window.
- `gif_valid`  out  1  1 when the current scan position is inside the image window.
- `frame_idx`  out  8  index of the frame currently displayed.
- `frame_start`  out  1  one-cycle pulse when `frame_idx` changes.

## Operation
- Edge detect: `fbclk_d` registers `framebufferClk`. An advance occurs in any cycle where `framebufferClk` = 1 and `fbclk_d` = 0.
- Scan counters `x` (0..LCD_W-1) and `y` (0..LCD_H-1):
  - `x` increments on each advance.
  - At `x` = LCD_W-1, `x` wraps to 0 and `y` increments.
  - At (LCD_W-1, LCD_H-1), both wrap to (0,0). This is a *screen wrap*.
  - These counters are cycle-identical to the renderer's counters.
- In-window test: `in_win` = IMG_X0 ≤ x < IMG_X0+IMG_W and IMG_Y0 ≤ y < IMG_Y0+IMG_H.
- Pixel offset `pix_off`, range 0..IMG_W·IMG_H-1:
  - Increments once per advance whose pre-advance position is in-window.
  - Clears to 0 on a screen wrap.
- `frame_base` equals frame_idx·IMG_W·IMG_H. It is maintained by an accumulator (add IMG_W·IMG_H per frame, 0 on wrap/restart). No multiplier.
- Fetch: one cycle after an advance, `mem_addr` ← frame_base + pix_off and `mem_rd` ← `in_win`. `mem_rd` is 0 at all other times.
- Output stage:
  - `gif_valid` ← the `in_win` value carried down the pipeline.
  - `gif_pixel` ← `mem_data` if valid, else 16'h0000.
- Sequencer: the refresh counter `rcnt` (0..FRAME_DELAY-1) updates only on a screen wrap.
  - If a restart is pending: `frame_idx` ← 0, `frame_base` ← 0, `rcnt` ← 0, clear pending, pulse `frame_start`. Restart wins over a simultaneous advance.
  - Else if `play` = 1 and `rcnt` = FRAME_DELAY-1: `rcnt` ← 0, `frame_idx` ← frame_idx+1 (NUM_FRAMES-1 wraps to 0), `frame_base` updated to match, pulse `frame_start`.
  - Else if `play` = 1: `rcnt` increments.
  - `play` = 0: `rcnt` and `frame_idx` hold.
- `restart` sets the pending flag in any cycle; it never changes `frame_idx` mid-screen. A repeated restart while pending is harmless.
- NUM_FRAMES = 1: `frame_idx` stays 0, but `frame_start` still pulses every FRAME_DELAY wraps.

## Timing
- Reset values: `x` = `y` = 0, `fbclk_d` = 0, `pix_off` = 0, `rcnt` = 0, pending = 0.
- Output reset values: `mem_addr` = 0, `mem_rd` = 0, `gif_pixel` = 0, `gif_valid` = 0, `frame_idx` = 0, `frame_start` = 0.
- Let edge E be the clock edge at which `x`/`y` advance.
  - `mem_addr`/`mem_rd` update at E+1.
  - The memory samples at E+2.
  - `gif_pixel`/`gif_valid` update at E+3 and hold until the next advance's E+3.
- The driver guarantees at least 4 `clk` cycles between `framebufferClk` rising edges. Behaviour with closer edges is undefined.
- `frame_idx`/`frame_base` change at the screen-wrap edge E. The first fetch of the new screen uses the new base.
- `frame_start` is high for exactly the one cycle after E.
- Reset asserted mid-screen returns everything to reset values immediately. Scan and fetch resume from (0,0) after release.

## Test plan
- Reset, no strobes → all outputs 0; `mem_rd` never asserts.
- First screen with strobes every 4 cycles:
  - (80,80) → `mem_addr` 0;
  - (239,80) → 159;
  - (80,81) → 160;
  - (239,199) → 19199;
  - (79,80) and (240,80) → `mem_rd` 0 and `gif_valid` 0.
  - `gif_pixel` equals model memory data at E+3.
- `play` = 1 for 6 screens → `frame_idx` 1 with a single `frame_start` pulse; first window address 19200. After 48 screens, `frame_idx` wraps 7→0.
- `play` = 0 across 10 screens → `frame_idx` and `rcnt` hold. Re-asserting `play` resumes counting from the held `rcnt`.
- `restart` pulse at (100,150) during frame 3 → `frame_idx` stays 3 until the screen wrap, then 0. A `restart` coinciding with a scheduled advance yields 0.
- Assert `reset_n` low mid-window during frame 5 → outputs 0 immediately. After release, the scan restarts at (0,0) with `frame_idx` 0.
